pwm_capture: RTL and testbench
==============================

# pwm_capture

PWM capture block: measures high time and period of an incoming PWM waveform and reports them in the same encoding the `pwm` generator takes (`pulse_width`, `max_counter`). Sits on GPIO/sensor inputs for duty-cycle readback, and in loopback against `pwm` for self-test. `pwm_i` is asynchronous; the block synchronises it internally. Results are registered and flagged by a one-cycle valid pulse.

## Interface
- `CtrSize`, default 8: width of the measurement outputs. The internal cycle counter is `CtrSize+1` bits.
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `enable_i`  in  1  capture enable. Low forces IDLE.
- `pwm_i`  in  1  asynchronous PWM input.
- `pulse_width_o`  out  CtrSize  high cycles of the last complete period.
- `period_o`  out  CtrSize  last complete period in cycles, minus 1.
- `valid_o`  out  1  one-cycle pulse when both outputs update.
- `timeout_o`  out  1  one-cycle pulse: no expected edge within 2^CtrSize cycles.
- `level_o`  out  1  synchronised input level; distinguishes 0% from 100% duty after a timeout.

## Operation
- **Synchroniser and edge detect:** `pwm_i` passes through 2 flops to give `pwm_q`; one further flop gives `pwm_prev`.
  - rise = `pwm_q & ~pwm_prev`; fall = `~pwm_q & pwm_prev`.
  - `level_o = pwm_q`.
- **FSM states:** IDLE, ARM, HIGH, LOW. `cnt` is the `CtrSize+1`-bit counter.
- **IDLE:**
  - `enable_i=1` → ARM.
  - Edges are ignored.
- **ARM:** rise → `cnt<=1`, go to HIGH. No timeout in ARM.
- **HIGH:** `cnt<=cnt+1` each cycle.
  - If `cnt == 2^CtrSize`: pulse `timeout_o` and go to ARM. Timeout takes priority over a same-cycle fall.
  - Else on fall: `hcnt<=cnt[CtrSize-1:0]` and go to LOW.
- **LOW:** `cnt<=cnt+1` each cycle.
  - On rise: `pulse_width_o<=hcnt`, `period_o<=cnt-1` (truncated to CtrSize), pulse `valid_o`, `cnt<=1`, stay measuring (→ HIGH).
  - Else if `cnt == 2^CtrSize`: pulse `timeout_o` and go to ARM.
- **Meaning of the counts:** `cnt` held at the fall equals the number of high cycles H. `cnt` held at the next rise equals the period P.
  - So `period_o = P-1`, which matches the generator's `max_counter`.
  - `pulse_width_o = H`, which matches the generator's `pulse_width` when `pulse_width <= max_counter`.
- **Valid range:** 2 ≤ P ≤ 2^CtrSize and 1 ≤ H ≤ P-1. Anything longer produces a timeout, not a truncated result.
- **enable_i low in any state:** go to IDLE next cycle.
  - `valid_o` and `timeout_o` are 0.
  - `pulse_width_o` and `period_o` hold their last values.
- **Re-enable:** goes to ARM. The first `valid_o` requires two rising edges seen in ARM/HIGH/LOW. A level already high on entering ARM is not a rise.
- **Reset:** all registers are 0, including the sync flops. State is IDLE. Outputs `pulse_width_o=0`, `period_o=0`, `valid_o=0`, `timeout_o=0`, `level_o=0`. Reset mid-measurement discards partial counts.

## Timing
- **Input latency:** an edge on `pwm_i` (setup met) is visible as rise/fall 2 cycles later (cycle after `pwm_q` changes vs `pwm_prev`). Edge-to-edge intervals are preserved exactly.
- **Output latency:** `valid_o` is asserted 1 cycle after the rise is detected. Outputs update in the same cycle `valid_o` is high.
- **Steady-state throughput:** one `valid_o` per input period, spaced exactly P cycles apart.
- **Timeout timing:**
  - HIGH: `timeout_o` fires when the signal has been high for 2^CtrSize cycles.
  - LOW: `timeout_o` fires when the period has reached 2^CtrSize+1 cycles without a rise.
- **Outputs:** all registered; no combinational path from inputs to outputs.

## Test plan
- **Loopback, typical:** `pwm` with `CtrSize=8`, `max_counter=9`, `pulse_width=3` → after the 2nd rise, `valid_o` every 10 cycles with `pulse_width_o=3`, `period_o=9`. `timeout_o` is never asserted.
- **Loopback, extremes:**
  - `max_counter=255`, `pulse_width=255` → `period_o=255`, `pulse_width_o=255`.
  - `max_counter=1`, `pulse_width=1` → `period_o=1`, `pulse_width_o=1`, `valid_o` every 2 cycles.
- **100% and 0% duty:**
  - `pulse_width=12`, `max_counter=9` (stuck high) → one `timeout_o` after 256 high cycles, `level_o=1`, then no `valid_o`.
  - Drive low for 300 cycles after a valid period → `timeout_o` once, `level_o=0`.
- **Enable handling:** drop `enable_i` mid-HIGH for 5 cycles, then restore → no `valid_o` until two new rises. Old `pulse_width_o`/`period_o` hold throughout.
- **Reset mid-LOW:** assert `rst_i` for 1 cycle → all outputs 0 the next cycle. The first `valid_o` comes only after two subsequent rises.
- **Timeout priority:** a fall detected in the same cycle `cnt` reaches 256 in HIGH → `timeout_o=1`, `valid_o=0`, state ARM.

Source files
------------

// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source/consumer and the pwm_capture block.
// The master side drives the waveform and the enable and reads back the results;
// the slave side is the capture block itself.
interface pwm_capture_if #(
   parameter int unsigned CtrSize = 8
);

   logic               enable_i;
   logic               pwm_i;
   logic [CtrSize-1:0] pulse_width_o;
   logic [CtrSize-1:0] period_o;
   logic               valid_o;
   logic               timeout_o;
   logic               level_o;

   modport master (
      output enable_i,
      output pwm_i,
      input  pulse_width_o,
      input  period_o,
      input  valid_o,
      input  timeout_o,
      input  level_o
   );

   modport slave (
      input  enable_i,
      input  pwm_i,
      output pulse_width_o,
      output period_o,
      output valid_o,
      output timeout_o,
      output level_o
   );

endinterface

// File: rtl/pwm_capture.sv
// PWM capture: measures the high time and period of an asynchronous PWM input.
// Results use the same encoding as the pwm generator: pulse_width_o is the
// number of high cycles, period_o is the period length minus one.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | capture disabled; edges ignored, results held
// ST_ARM   | waiting for the first rising edge; no timeout here
// ST_HIGH  | counting high cycles since the last rise
// ST_LOW   | high time captured, counting on until the next rise
module pwm_capture #(
   parameter int unsigned CtrSize = 8
) (
   input logic          clk_i,
   input logic          rst_i,
   pwm_capture_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_HIGH = 2'd2,
      ST_LOW  = 2'd3
   } state_t;

   // A full-scale count (2^CtrSize) needs the extra counter bit.
   localparam logic [CtrSize:0]   CntMax = {1'b1, {CtrSize{1'b0}}};
   localparam logic [CtrSize:0]   CntOne = {{CtrSize{1'b0}}, 1'b1};
   localparam logic [CtrSize-1:0] OutOne = {{(CtrSize-1){1'b0}}, 1'b1};

   logic pwm_s1;
   logic pwm_q;
   logic pwm_prev;
   logic rise;
   logic fall;

   state_t             state_q,   state_d;
   logic [CtrSize:0]   cnt_q,     cnt_d;
   logic [CtrSize-1:0] hcnt_q,    hcnt_d;
   logic [CtrSize-1:0] pw_q,      pw_d;
   logic [CtrSize-1:0] per_q,     per_d;
   logic               valid_q,   valid_d;
   logic               timeout_q, timeout_d;
   logic               cnt_full;

   // Two-flop synchroniser plus one history flop for edge detection.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pwm_s1   <= 1'b0;
         pwm_q    <= 1'b0;
         pwm_prev <= 1'b0;
      end else begin
         pwm_s1   <= bus.pwm_i;
         pwm_q    <= pwm_s1;
         pwm_prev <= pwm_q;
      end
   end

   assign rise     = pwm_q & ~pwm_prev;
   assign fall     = ~pwm_q & pwm_prev;
   assign cnt_full = (cnt_q == CntMax);

   // State, counters and registered results.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hcnt_q    <= '0;
         pw_q      <= '0;
         per_q     <= '0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hcnt_q    <= hcnt_d;
         pw_q      <= pw_d;
         per_q     <= per_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state and measurement logic. The counter restarts at 1 on the rise
   // so that its value at the fall is H and at the next rise is P.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hcnt_d    = hcnt_q;
      pw_d      = pw_q;
      per_d     = per_q;
      valid_d   = 1'b0;
      timeout_d = 1'b0;

      if (!bus.enable_i) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d = ST_ARM;
            end
            ST_ARM: begin
               if (rise) begin
                  cnt_d   = CntOne;
                  state_d = ST_HIGH;
               end
            end
            ST_HIGH: begin
               cnt_d = cnt_q + CntOne;
               // A full-scale high time is out of range even if the fall
               // arrives on the same cycle, so the timeout wins.
               if (cnt_full) begin
                  timeout_d = 1'b1;
                  state_d   = ST_ARM;
               end else if (fall) begin
                  hcnt_d  = cnt_q[CtrSize-1:0];
                  state_d = ST_LOW;
               end
            end
            ST_LOW: begin
               cnt_d = cnt_q + CntOne;
               // A rise at full scale is still a legal 2^CtrSize period.
               if (rise) begin
                  pw_d    = hcnt_q;
                  per_d   = cnt_q[CtrSize-1:0] - OutOne;
                  valid_d = 1'b1;
                  cnt_d   = CntOne;
                  state_d = ST_HIGH;
               end else if (cnt_full) begin
                  timeout_d = 1'b1;
                  state_d   = ST_ARM;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign bus.pulse_width_o = pw_q;
   assign bus.period_o      = per_q;
   assign bus.valid_o       = valid_q;
   assign bus.timeout_o     = timeout_q;
   assign bus.level_o       = pwm_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed PWM patterns, a timestamp-based reference
// model checked every cycle, and hand-computed expectations per scenario.
module tb_pwm_capture;

   localparam int N    = 8;
   localparam int FULL = 1 << N;

   localparam int P_OFF  = 0;
   localparam int P_WAIT = 1;
   localparam int P_HI   = 2;
   localparam int P_LO   = 3;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   pwm_capture_if #(.CtrSize(N)) bus ();

   pwm_capture #(.CtrSize(N)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   // Statistics gathered from the DUT outputs for scenario-level checks.
   int n_valid     = 0;
   int n_timeout   = 0;
   int last_valid  = -1;
   int valid_gap   = 0;

   // Reference model: synchronised level history plus the timestamps of the
   // last rise and the measured high time.
   bit m_s1, m_q, m_prev;
   int m_phase  = P_OFF;
   int rise_t   = 0;
   int high_len = 0;
   int t        = 0;
   int e_pw     = 0;
   int e_per    = 0;
   bit e_valid  = 1'b0;
   bit e_tmo    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, t, act, exp);
      end
   endtask

   task automatic model_step();
      bit r, f;
      int el;
      if (rst) begin
         m_s1 = 0; m_q = 0; m_prev = 0;
         m_phase = P_OFF;
         e_pw = 0; e_per = 0; e_valid = 0; e_tmo = 0;
      end else begin
         r  = m_q && !m_prev;
         f  = !m_q && m_prev;
         el = t - rise_t;
         e_valid = 0;
         e_tmo   = 0;
         if (!bus.enable_i) begin
            m_phase = P_OFF;
         end else if (m_phase == P_OFF) begin
            m_phase = P_WAIT;
         end else if (m_phase == P_WAIT) begin
            if (r) begin
               rise_t  = t;
               m_phase = P_HI;
            end
         end else if (m_phase == P_HI) begin
            if (el == FULL) begin
               e_tmo   = 1;
               m_phase = P_WAIT;
            end else if (f) begin
               high_len = el;
               m_phase  = P_LO;
            end
         end else begin
            if (r) begin
               e_pw    = high_len;
               e_per   = (el - 1) % FULL;
               e_valid = 1;
               rise_t  = t;
               m_phase = P_HI;
            end else if (el == FULL) begin
               e_tmo   = 1;
               m_phase = P_WAIT;
            end
         end
         m_prev = m_q;
         m_q    = m_s1;
         m_s1   = bus.pwm_i;
      end
      t++;
   endtask

   // Every-cycle comparison against the model, just after the active edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         model_step();
         check("valid_o",       32'(bus.valid_o),       32'(e_valid));
         check("timeout_o",     32'(bus.timeout_o),     32'(e_tmo));
         check("level_o",       32'(bus.level_o),       32'(m_q));
         check("pulse_width_o", 32'(bus.pulse_width_o), 32'(e_pw));
         check("period_o",      32'(bus.period_o),      32'(e_per));
         if (bus.valid_o === 1'b1) begin
            if (last_valid >= 0) valid_gap = t - last_valid;
            last_valid = t;
            n_valid++;
         end
         if (bus.timeout_o === 1'b1) n_timeout++;
      end
   end

   task automatic clear_stats();
      n_valid    = 0;
      n_timeout  = 0;
      last_valid = -1;
      valid_gap  = 0;
   endtask

   // Behaves like the pwm generator: high while counter < pulse_width.
   task automatic gen(input int mc, input int pw, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.pwm_i = ((i % (mc + 1)) < pw);
      end
   endtask

   task automatic hold(input bit lvl, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.pwm_i = lvl;
      end
   endtask

   initial begin
      rst          = 1'b1;
      bus.enable_i = 1'b0;
      bus.pwm_i    = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_pw",      32'(bus.pulse_width_o), 32'd0);
      check("reset_period",  32'(bus.period_o),      32'd0);
      check("reset_valid",   32'(bus.valid_o),       32'd0);
      check("reset_timeout", 32'(bus.timeout_o),     32'd0);
      check("reset_level",   32'(bus.level_o),       32'd0);
      rst = 1'b0;

      // Typical loopback: 12 rises, 11 results spaced 10 cycles apart.
      bus.enable_i = 1'b1;
      clear_stats();
      gen(9, 3, 120);
      check("typ_count",   32'(n_valid),           32'd11);
      check("typ_gap",     32'(valid_gap),         32'd10);
      check("typ_pw",      32'(bus.pulse_width_o), 32'd3);
      check("typ_period",  32'(bus.period_o),      32'd9);
      check("typ_timeout", 32'(n_timeout),         32'd0);

      // Full-scale period with 255 high cycles.
      clear_stats();
      gen(255, 255, 4 * 256);
      check("max_gap",     32'(valid_gap),         32'd256);
      check("max_pw",      32'(bus.pulse_width_o), 32'd255);
      check("max_period",  32'(bus.period_o),      32'd255);
      check("max_timeout", 32'(n_timeout),         32'd0);

      // Shortest legal period.
      clear_stats();
      gen(1, 1, 40);
      check("min_gap",     32'(valid_gap),         32'd2);
      check("min_pw",      32'(bus.pulse_width_o), 32'd1);
      check("min_period",  32'(bus.period_o),      32'd1);
      check("min_timeout", 32'(n_timeout),         32'd0);

      // 100% duty: pulse_width beyond max_counter leaves the line high.
      gen(9, 12, 20);
      clear_stats();
      gen(9, 12, 380);
      check("hi_timeout", 32'(n_timeout),     32'd1);
      check("hi_valid",   32'(n_valid),       32'd0);
      check("hi_level",   32'(bus.level_o),   32'd1);

      // 0% duty after a valid period.
      gen(9, 3, 40);
      check("lo_pre_pw",     32'(bus.pulse_width_o), 32'd3);
      check("lo_pre_period", 32'(bus.period_o),      32'd9);
      clear_stats();
      hold(1'b0, 300);
      check("lo_timeout", 32'(n_timeout),   32'd1);
      check("lo_valid",   32'(n_valid),     32'd0);
      check("lo_level",   32'(bus.level_o), 32'd0);

      // Enable dropped mid-HIGH for 5 cycles.
      gen(9, 5, 60);
      check("en_pre_pw", 32'(bus.pulse_width_o), 32'd5);
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         bus.pwm_i    = ((i % 10) < 5);
         bus.enable_i = !(i >= 32 && i < 37);
         if (i == 32) clear_stats();
         if (i == 36) begin
            check("en_hold_pw",     32'(bus.pulse_width_o), 32'd5);
            check("en_hold_period", 32'(bus.period_o),      32'd9);
         end
         if (i == 48) check("en_no_early_valid", 32'(n_valid), 32'd0);
      end
      check("en_valid_after", 32'(n_valid), 32'd1);
      bus.enable_i = 1'b1;

      // One-cycle reset while in LOW.
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         bus.pwm_i = ((i % 10) < 3);
         rst       = (i == 26);
         if (i == 27) begin
            check("rst_pw",     32'(bus.pulse_width_o), 32'd0);
            check("rst_period", 32'(bus.period_o),      32'd0);
            check("rst_valid",  32'(bus.valid_o),       32'd0);
            clear_stats();
         end
         if (i == 38) check("rst_no_early_valid", 32'(n_valid), 32'd0);
      end
      check("rst_valid_after", 32'(n_valid),           32'd2);
      check("rst_pw_after",    32'(bus.pulse_width_o), 32'd3);
      rst = 1'b0;

      // Fall detected on the same cycle the high count reaches 256.
      bus.enable_i = 1'b0;
      hold(1'b0, 2);
      bus.enable_i = 1'b1;
      hold(1'b0, 5);
      clear_stats();
      hold(1'b1, 256);
      hold(1'b0, 12);
      gen(9, 3, 10);
      check("prio_timeout",  32'(n_timeout), 32'd1);
      check("prio_no_valid", 32'(n_valid),   32'd0);
      gen(9, 3, 10);
      hold(1'b0, 3);
      check("prio_valid",  32'(n_valid),           32'd1);
      check("prio_pw",     32'(bus.pulse_width_o), 32'd3);
      check("prio_period", 32'(bus.period_o),      32'd9);

      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
